rx_frame_sequencer: RTL and testbench
=====================================

// Module: rx_frame_sequencer
// PURPOSE
//  Sequences the OFDM receiver datapath for one packet after the synchronizer locks.
//  Strips the cyclic prefix and gates each FFT-length symbol into the FFT with
//  valid/ready handshaking. Counts symbols per frame and frames per packet.
//  At packet end, or on a stalled stream, re-arms the synchronizer with a resync pulse.
// PARAMETERS
//  FFT_LEN            64  samples per symbol body forwarded to FFT
//  CP_LEN             16  cyclic-prefix samples discarded before each symbol
//  SYM_PER_FRAME      4   OFDM symbols per frame
//  NO_OF_FRAME_IN_PAK 4   frames per packet
//  TIMEOUT            256 idle cycles (no accepted sample) in CP/SYM before abort
//  SAMP_W 7, SYM_W 3, FRM_W 3, TO_W 9   counter widths; each holds its max count
// PORTS
//  CLK        in  1     rising-edge clock, sole clock domain
//  s_RST_n    in  1     synchronous reset, active low
//  sync_found in  1     one-cycle pulse from synchronizer: packet start located
//  in_strobe  in  1     input sample valid
//  in_ready   out 1     sequencer accepts sample this cycle (comb.)
//  fft_ready  in  1     FFT can take a sample
//  fft_valid  out 1     sample forwarded to FFT this cycle (comb.)
//  fft_sof    out 1     with fft_valid: first sample of symbol
//  fft_eof    out 1     with fft_valid: last sample of symbol
//  sync_en    out 1     synchronizer search enable (HUNT state)
//  resync_rst out 1     one-cycle reset pulse to synchronizer/resetter chain
//  pkt_done   out 1     one-cycle pulse: full packet delivered
//  seq_err    out 1     one-cycle pulse: timeout abort
//  sym_idx    out SYM_W current symbol in frame
//  frame_idx  out FRM_W current frame in packet
// BEHAVIOUR
//  Reset: while s_RST_n=0 all outputs 0, counters 0. State=HUNT on first cycle after release.
//  States: HUNT, CP, SYM, DONE, ABORT. Moore decode for sync_en/pkt_done/seq_err/resync_rst.
//  Accept rule: acc = in_strobe & in_ready. fft_valid = in_strobe & (state==SYM) & fft_ready.
//  HUNT: sync_en=1, in_ready=1; sync_found -> CP, clear samp/sym/frame/idle counters.
//   A sample strobed in the same cycle as sync_found belongs to sync, not counted.
//  CP: in_ready=1 regardless of fft_ready; acc increments samp_cnt.
//   acc at samp_cnt==CP_LEN-1 -> SYM, samp_cnt<=0.
//  SYM: in_ready=fft_ready; fft_sof when samp_cnt==0, fft_eof when samp_cnt==FFT_LEN-1.
//   acc at FFT_LEN-1: samp_cnt<=0. If sym_idx<SYM_PER_FRAME-1: sym_idx++ and -> CP.
//   Else sym_idx<=0. If frame_idx<NO_OF_FRAME_IN_PAK-1: frame_idx++ and -> CP.
//   Else -> DONE.
//  DONE: 1 cycle; pkt_done=1, resync_rst=1, in_ready=0 -> HUNT, counters cleared.
//  Timeout: idle_cnt clears on acc, else increments in CP/SYM.
//   idle_cnt==TIMEOUT-1 without acc -> ABORT.
//   Stall on fft_ready=0 counts as idle.
//  ABORT: 1 cycle; seq_err=1, resync_rst=1, in_ready=0 -> HUNT, counters cleared.
//  sync_found outside HUNT is ignored. acc and timeout in the same cycle: acc wins.
//  Reset mid-packet: immediate return to HUNT-after-release; no pkt_done/seq_err issued.
// TESTING
//  T1 sync_found, then in_strobe=1, fft_ready=1 continuously -> 1280 accepted samples.
//     1024 fft_valid, 16 sof/eof pairs; pkt_done+resync_rst for 1 cycle right after sample 1280.
//  T2 As T1 with fft_ready toggled 1/0 in SYM -> still 1024 fft_valid.
//     in_ready=0 whenever fft_ready=0 in SYM; in_ready=1 throughout CP.
//  T3 in_strobe held 0 for 300 cycles mid-SYM of frame 2 -> seq_err+resync_rst at idle cycle 256.
//     sync_en=1 next cycle; sym_idx=frame_idx=0.
//  T4 s_RST_n=0 for 3 cycles mid-CP of frame 1 -> all outputs 0 during reset.
//     HUNT after release; a new sync_found restarts at frame_idx=0.
//  T5 sync_found pulsed during SYM -> ignored; sym_idx/frame_idx sequence unchanged.
//  T6 sync_found and in_strobe same cycle -> first counted CP sample is the next strobe.
//     Symbol 0 sof coincides with accepted sample 17.

Source files
------------

// File: rtl/rx_frame_sequencer.sv
// rtl/rx_frame_sequencer.sv - OFDM receive packet sequencer: CP strip, FFT gating, frame/packet counting, resync
//
// Purpose:
//   After the synchronizer reports a packet start, discards the cyclic prefix
//   and forwards each FFT_LEN-sample symbol body to the FFT. It counts symbols
//   per frame and frames per packet. At packet end, or when the input stream
//   stalls for TIMEOUT cycles, it pulses resync_rst to re-arm the synchronizer.
//
// Ports:
//   CLK         in   rising-edge clock
//   s_RST_n     in   synchronous reset, active low; all outputs forced 0 while low
//   sync_found  in   one-cycle packet-start pulse, honoured only in HUNT
//   in_strobe   in   input sample valid
//   in_ready    out  sample accepted this cycle when in_strobe is also high
//   fft_ready   in   FFT can take a sample
//   fft_valid   out  sample forwarded to the FFT this cycle
//   fft_sof     out  first sample of a symbol (qualified by fft_valid)
//   fft_eof     out  last sample of a symbol (qualified by fft_valid)
//   sync_en     out  synchronizer search enable
//   resync_rst  out  one-cycle synchronizer reset pulse
//   pkt_done    out  one-cycle pulse: full packet delivered
//   seq_err     out  one-cycle pulse: timeout abort
//   sym_idx     out  current symbol within frame
//   frame_idx   out  current frame within packet

module rx_frame_sequencer #(
  parameter int FFT_LEN            = 64,
  parameter int CP_LEN             = 16,
  parameter int SYM_PER_FRAME      = 4,
  parameter int NO_OF_FRAME_IN_PAK = 4,
  parameter int TIMEOUT            = 256,
  parameter int SAMP_W             = 7,
  parameter int SYM_W              = 3,
  parameter int FRM_W              = 3,
  parameter int TO_W               = 9
) (
  input  logic             CLK,
  input  logic             s_RST_n,
  input  logic             sync_found,
  input  logic             in_strobe,
  output logic             in_ready,
  input  logic             fft_ready,
  output logic             fft_valid,
  output logic             fft_sof,
  output logic             fft_eof,
  output logic             sync_en,
  output logic             resync_rst,
  output logic             pkt_done,
  output logic             seq_err,
  output logic [SYM_W-1:0] sym_idx,
  output logic [FRM_W-1:0] frame_idx
);

  typedef enum logic [2:0] {
    HUNT  = 3'd0,
    CP    = 3'd1,
    SYM   = 3'd2,
    DONE  = 3'd3,
    ABORT = 3'd4
  } state_t;

  localparam logic [SAMP_W-1:0] CP_LAST  = SAMP_W'(CP_LEN - 1);
  localparam logic [SAMP_W-1:0] FFT_LAST = SAMP_W'(FFT_LEN - 1);
  localparam logic [SYM_W-1:0]  SYM_LAST = SYM_W'(SYM_PER_FRAME - 1);
  localparam logic [FRM_W-1:0]  FRM_LAST = FRM_W'(NO_OF_FRAME_IN_PAK - 1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [SAMP_W-1:0] samp_cnt, samp_nxt;
  logic [SYM_W-1:0]  sym_cnt, sym_nxt;
  logic [FRM_W-1:0]  frm_cnt, frm_nxt;
  logic [TO_W-1:0]   idle_cnt, idle_nxt;
  logic              ready_int;
  logic              acc;

  always_ff @(posedge CLK) begin
    if (!s_RST_n) begin
      state    <= HUNT;
      samp_cnt <= '0;
      sym_cnt  <= '0;
      frm_cnt  <= '0;
      idle_cnt <= '0;
    end else begin
      state    <= state_nxt;
      samp_cnt <= samp_nxt;
      sym_cnt  <= sym_nxt;
      frm_cnt  <= frm_nxt;
      idle_cnt <= idle_nxt;
    end
  end

  // The CP is discarded, so it never waits on the FFT; only symbol bodies
  // are back-pressured by fft_ready.
  always_comb begin
    ready_int = 1'b0;
    case (state)
      HUNT:    ready_int = 1'b1;
      CP:      ready_int = 1'b1;
      SYM:     ready_int = fft_ready;
      default: ready_int = 1'b0;
    endcase
  end

  assign acc = in_strobe & ready_int;

  always_comb begin
    state_nxt = state;
    samp_nxt  = samp_cnt;
    sym_nxt   = sym_cnt;
    frm_nxt   = frm_cnt;
    idle_nxt  = idle_cnt;

    case (state)
      HUNT: begin
        // A sample strobed alongside sync_found is part of the sync pattern
        // and is deliberately not counted.
        if (sync_found) begin
          state_nxt = CP;
          samp_nxt  = '0;
          sym_nxt   = '0;
          frm_nxt   = '0;
          idle_nxt  = '0;
        end
      end

      CP: begin
        if (acc) begin
          idle_nxt = '0;
          if (samp_cnt == CP_LAST) begin
            samp_nxt  = '0;
            state_nxt = SYM;
          end else begin
            samp_nxt = samp_cnt + 1'b1;
          end
        end else if (idle_cnt == TO_LAST) begin
          state_nxt = ABORT;
        end else begin
          idle_nxt = idle_cnt + 1'b1;
        end
      end

      SYM: begin
        // An accepted sample always wins over a coincident timeout.
        if (acc) begin
          idle_nxt = '0;
          if (samp_cnt == FFT_LAST) begin
            samp_nxt = '0;
            if (sym_cnt != SYM_LAST) begin
              sym_nxt   = sym_cnt + 1'b1;
              state_nxt = CP;
            end else begin
              sym_nxt = '0;
              if (frm_cnt != FRM_LAST) begin
                frm_nxt   = frm_cnt + 1'b1;
                state_nxt = CP;
              end else begin
                state_nxt = DONE;
              end
            end
          end else begin
            samp_nxt = samp_cnt + 1'b1;
          end
        end else if (idle_cnt == TO_LAST) begin
          state_nxt = ABORT;
        end else begin
          idle_nxt = idle_cnt + 1'b1;
        end
      end

      DONE, ABORT: begin
        state_nxt = HUNT;
        samp_nxt  = '0;
        sym_nxt   = '0;
        frm_nxt   = '0;
        idle_nxt  = '0;
      end

      default: begin
        state_nxt = HUNT;
        samp_nxt  = '0;
        sym_nxt   = '0;
        frm_nxt   = '0;
        idle_nxt  = '0;
      end
    endcase
  end

  // Every output is gated by s_RST_n so nothing leaks out while reset is held,
  // including the cycle before the first reset edge.
  logic in_sym;
  assign in_sym = (state == SYM);

  assign in_ready   = s_RST_n & ready_int;
  assign fft_valid  = s_RST_n & in_strobe & in_sym & fft_ready;
  assign fft_sof    = fft_valid & (samp_cnt == '0);
  assign fft_eof    = fft_valid & (samp_cnt == FFT_LAST);
  assign sync_en    = s_RST_n & (state == HUNT);
  assign pkt_done   = s_RST_n & (state == DONE);
  assign seq_err    = s_RST_n & (state == ABORT);
  assign resync_rst = s_RST_n & ((state == DONE) | (state == ABORT));
  assign sym_idx    = s_RST_n ? sym_cnt : '0;
  assign frame_idx  = s_RST_n ? frm_cnt : '0;

endmodule

// File: tb/tb_rx_frame_sequencer.sv
// tb/tb_rx_frame_sequencer.sv - self-checking bench for rx_frame_sequencer against a packet-position model

module tb_rx_frame_sequencer;

  localparam int FFT  = 64;
  localparam int CPL  = 16;
  localparam int SPF  = 4;
  localparam int NFR  = 4;
  localparam int TO   = 256;
  localparam int SEG  = FFT + CPL;
  localparam int PKT  = SEG * SPF * NFR;

  localparam int M_HUNT = 0, M_RUN = 1, M_DONE = 2, M_ABORT = 3;

  logic       CLK;
  logic       s_RST_n;
  logic       sync_found;
  logic       in_strobe;
  logic       fft_ready;
  logic       in_ready, fft_valid, fft_sof, fft_eof;
  logic       sync_en, resync_rst, pkt_done, seq_err;
  logic [2:0] sym_idx, frame_idx;

  int errors = 0;
  int checks = 0;

  // Model: packet described only by the number of samples accepted so far.
  int mode = M_HUNT;
  int pos  = 0;
  int idle = 0;

  rx_frame_sequencer dut (
    .CLK        (CLK),
    .s_RST_n    (s_RST_n),
    .sync_found (sync_found),
    .in_strobe  (in_strobe),
    .in_ready   (in_ready),
    .fft_ready  (fft_ready),
    .fft_valid  (fft_valid),
    .fft_sof    (fft_sof),
    .fft_eof    (fft_eof),
    .sync_en    (sync_en),
    .resync_rst (resync_rst),
    .pkt_done   (pkt_done),
    .seq_err    (seq_err),
    .sym_idx    (sym_idx),
    .frame_idx  (frame_idx)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  wire [13:0] obs = {in_ready, fft_valid, fft_sof, fft_eof, sync_en, resync_rst,
                     pkt_done, seq_err, sym_idx, frame_idx};

  // Expected output vector for the current model position and driven inputs.
  function automatic logic [13:0] model_out();
    logic ir, fv, sof, eof, se, rr, pd, er;
    int   sy, fr, off;
    ir = 0; fv = 0; sof = 0; eof = 0; se = 0; rr = 0; pd = 0; er = 0; sy = 0; fr = 0;
    if (s_RST_n === 1'b1) begin
      case (mode)
        M_HUNT: begin ir = 1; se = 1; end
        M_RUN: begin
          off = pos % SEG;
          if (off < CPL) ir = 1;
          else begin
            ir  = fft_ready;
            fv  = in_strobe & fft_ready;
            sof = fv && (off == CPL);
            eof = fv && (off == SEG - 1);
          end
          sy = (pos / SEG) % SPF;
          fr = pos / (SEG * SPF);
        end
        M_DONE: begin pd = 1; rr = 1; fr = NFR - 1; end
        default: begin
          er = 1; rr = 1;
          sy = (pos / SEG) % SPF;
          fr = pos / (SEG * SPF);
        end
      endcase
    end
    return {ir, fv, sof, eof, se, rr, pd, er, 3'(sy), 3'(fr)};
  endfunction

  function automatic void model_advance(input logic ir);
    if (s_RST_n !== 1'b1) begin
      mode = M_HUNT; pos = 0; idle = 0;
    end else begin
      case (mode)
        M_HUNT: if (sync_found) begin mode = M_RUN; pos = 0; idle = 0; end
        M_RUN: begin
          if (in_strobe && ir) begin
            pos++; idle = 0;
            if (pos == PKT) mode = M_DONE;
          end else begin
            idle++;
            if (idle == TO) mode = M_ABORT;
          end
        end
        default: begin mode = M_HUNT; pos = 0; idle = 0; end
      endcase
    end
  endfunction

  // Advance one clock edge; inputs are held from posedge+1 to the next posedge.
  task automatic tick();
    logic [13:0] e;
    e = model_out();
    @(posedge CLK);
    model_advance(e[13]);
    #1;
  endtask

  task automatic test_reset();
    logic [13:0] e;
    s_RST_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sync_found = 1'($urandom); in_strobe = 1'($urandom); fft_ready = 1'($urandom);
      #4; e = model_out(); checks++;
      if (obs !== e) begin errors++; $display("FAIL reset_outputs cyc=%0d got=%b exp=%b", i, obs, e); end
      tick();
    end
    s_RST_n = 1'b1; sync_found = 0; in_strobe = 0; fft_ready = 1;
    #4; e = model_out(); checks++;
    if (obs !== e || sync_en !== 1'b1) begin errors++; $display("FAIL reset_release got=%b exp=%b", obs, e); end
    tick();
  endtask

  task automatic test_full_packet();
    logic [13:0] e;
    int acc_n = 0, fv_n = 0, sof_n = 0, eof_n = 0;
    bit done_seen = 0;
    sync_found = 1; in_strobe = 0; fft_ready = 1;
    #4; e = model_out(); checks++;
    if (obs !== e) begin errors++; $display("FAIL t1_sync got=%b exp=%b", obs, e); end
    tick(); sync_found = 0;
    for (int c = 0; c < 3000 && !done_seen; c++) begin
      in_strobe = 1; fft_ready = 1;
      #4; e = model_out(); checks++;
      if (obs !== e) begin errors++; $display("FAIL t1_cycle c=%0d got=%b exp=%b", c, obs, e); end
      if (pkt_done) begin
        done_seen = 1; checks++;
        if (acc_n !== PKT || resync_rst !== 1'b1) begin
          errors++; $display("FAIL t1_done_timing accepted=%0d exp=%0d resync=%b", acc_n, PKT, resync_rst);
        end
      end
      acc_n += int'(in_strobe & in_ready); fv_n += int'(fft_valid);
      sof_n += int'(fft_sof); eof_n += int'(fft_eof);
      tick();
    end
    in_strobe = 0;
    checks++; if (!done_seen) begin errors++; $display("FAIL t1_done_seen got=0 exp=1"); end
    checks++; if (fv_n !== SPF * NFR * FFT) begin errors++; $display("FAIL t1_fft_valid got=%0d exp=%0d", fv_n, SPF*NFR*FFT); end
    checks++; if (sof_n !== 16 || eof_n !== 16) begin errors++; $display("FAIL t1_sof_eof got=%0d/%0d exp=16/16", sof_n, eof_n); end
    #4; checks++;
    if (sync_en !== 1'b1 || pkt_done !== 1'b0) begin errors++; $display("FAIL t1_back_to_hunt sync_en=%b pkt_done=%b exp=1/0", sync_en, pkt_done); end
    tick();
  endtask

  task automatic test_fft_toggle();
    logic [13:0] e;
    int fv_n = 0, bad_ready = 0;
    bit done_seen = 0;
    sync_found = 1; in_strobe = 0; fft_ready = 1;
    tick(); sync_found = 0;
    for (int c = 0; c < 4000 && !done_seen; c++) begin
      in_strobe = 1; fft_ready = c[0];
      #4; e = model_out(); checks++;
      if (obs !== e) begin errors++; $display("FAIL t2_cycle c=%0d got=%b exp=%b", c, obs, e); end
      if (mode == M_RUN && (pos % SEG) >= CPL && !fft_ready && in_ready) bad_ready++;
      if (mode == M_RUN && (pos % SEG) < CPL && !in_ready) bad_ready++;
      if (pkt_done) done_seen = 1;
      fv_n += int'(fft_valid);
      tick();
    end
    in_strobe = 0; fft_ready = 1;
    checks++; if (!done_seen) begin errors++; $display("FAIL t2_done_seen got=0 exp=1"); end
    checks++; if (fv_n !== 1024) begin errors++; $display("FAIL t2_fft_valid got=%0d exp=1024", fv_n); end
    checks++; if (bad_ready !== 0) begin errors++; $display("FAIL t2_in_ready_rule violations=%0d exp=0", bad_ready); end
    tick();
  endtask

  task automatic test_timeout();
    logic [13:0] e;
    int err_at = -1;
    sync_found = 1; in_strobe = 0; fft_ready = 1;
    tick(); sync_found = 0;
    for (int c = 0; c < 2000 && pos < 2 * SEG * SPF + CPL + 10; c++) begin
      in_strobe = 1;
      #4; e = model_out(); checks++;
      if (obs !== e) begin errors++; $display("FAIL t3_run c=%0d got=%b exp=%b", c, obs, e); end
      tick();
    end
    for (int i = 0; i < 300; i++) begin
      in_strobe = 0;
      #4; e = model_out(); checks++;
      if (obs !== e) begin errors++; $display("FAIL t3_idle i=%0d got=%b exp=%b", i, obs, e); end
      if (seq_err && err_at < 0) err_at = i;
      if (err_at >= 0 && i == err_at + 1) begin
        checks++;
        if (sync_en !== 1'b1 || sym_idx !== 3'd0 || frame_idx !== 3'd0) begin
          errors++; $display("FAIL t3_after_abort sync_en=%b sym=%0d frm=%0d exp=1/0/0", sync_en, sym_idx, frame_idx);
        end
      end
      tick();
    end
    checks++;
    if (err_at !== TO) begin errors++; $display("FAIL t3_abort_cycle got=%0d exp=%0d", err_at, TO); end
  endtask

  task automatic test_reset_mid();
    logic [13:0] e;
    sync_found = 1; in_strobe = 0; fft_ready = 1;
    tick(); sync_found = 0;
    for (int c = 0; c < 1000 && pos < SEG * SPF + 5; c++) begin
      in_strobe = 1;
      #4; e = model_out(); checks++;
      if (obs !== e) begin errors++; $display("FAIL t4_run c=%0d got=%b exp=%b", c, obs, e); end
      tick();
    end
    s_RST_n = 0;
    for (int i = 0; i < 3; i++) begin
      #4; checks++;
      if (obs !== 14'd0) begin errors++; $display("FAIL t4_in_reset i=%0d got=%b exp=0", i, obs); end
      tick();
    end
    s_RST_n = 1; in_strobe = 0;
    #4; e = model_out(); checks++;
    if (obs !== e || sync_en !== 1'b1) begin errors++; $display("FAIL t4_hunt got=%b exp=%b", obs, e); end
    sync_found = 1;
    tick(); sync_found = 0;
    for (int c = 0; c < 100; c++) begin
      in_strobe = 1;
      #4; e = model_out(); checks++;
      if (obs !== e) begin errors++; $display("FAIL t4_restart c=%0d got=%b exp=%b", c, obs, e); end
      tick();
    end
    checks++;
    if (frame_idx !== 3'd0 || sym_idx !== 3'd1) begin errors++; $display("FAIL t4_indices sym=%0d frm=%0d exp=1/0", sym_idx, frame_idx); end
    s_RST_n = 0; in_strobe = 0; tick(); s_RST_n = 1; tick();
  endtask

  task automatic test_sync_ignore();
    logic [13:0] e;
    bit done_seen = 0;
    int pulses = 0;
    sync_found = 1; in_strobe = 0; fft_ready = 1;
    tick();
    for (int c = 0; c < 4000 && !done_seen; c++) begin
      in_strobe = 1; fft_ready = 1'($urandom_range(0, 3) != 0);
      sync_found = (mode == M_RUN && (pos % SEG) >= CPL && $urandom_range(0, 7) == 0);
      pulses += int'(sync_found);
      #4; e = model_out(); checks++;
      if (obs !== e) begin errors++; $display("FAIL t5_cycle c=%0d got=%b exp=%b", c, obs, e); end
      if (pkt_done) done_seen = 1;
      tick();
    end
    sync_found = 0; in_strobe = 0; fft_ready = 1;
    checks++;
    if (!done_seen || pulses == 0) begin errors++; $display("FAIL t5_done got=%0d pulses=%0d exp=1", done_seen, pulses); end
    tick();
  endtask

  task automatic test_sync_same_cycle();
    logic [13:0] e;
    int acc_n = 0, sof_at = -1;
    bit done_seen = 0;
    sync_found = 1; in_strobe = 1; fft_ready = 1;
    #4; e = model_out(); checks++;
    if (obs !== e) begin errors++; $display("FAIL t6_sync got=%b exp=%b", obs, e); end
    tick(); sync_found = 0;
    for (int c = 0; c < 3000 && !done_seen; c++) begin
      in_strobe = 1;
      #4; e = model_out(); checks++;
      if (obs !== e) begin errors++; $display("FAIL t6_cycle c=%0d got=%b exp=%b", c, obs, e); end
      if (in_strobe & in_ready) acc_n++;
      if (fft_sof && sof_at < 0) sof_at = acc_n;
      if (pkt_done) done_seen = 1;
      tick();
    end
    in_strobe = 0;
    checks++; if (sof_at !== CPL + 1) begin errors++; $display("FAIL t6_first_sof got=%0d exp=%0d", sof_at, CPL + 1); end
    checks++; if (acc_n !== PKT) begin errors++; $display("FAIL t6_accepted got=%0d exp=%0d", acc_n, PKT); end
    tick();
  endtask

  task automatic test_random();
    logic [13:0] e;
    bit done_seen = 0;
    sync_found = 0; in_strobe = 0;
    for (int c = 0; c < 12000 && !done_seen; c++) begin
      in_strobe  = 1'($urandom_range(0, 3) != 0);
      fft_ready  = 1'($urandom_range(0, 1));
      sync_found = (c == 3) || ($urandom_range(0, 31) == 0);
      #4; e = model_out(); checks++;
      if (obs !== e) begin errors++; $display("FAIL rand_cycle c=%0d got=%b exp=%b", c, obs, e); end
      if (pkt_done) done_seen = 1;
      tick();
    end
    sync_found = 0; in_strobe = 0;
    checks++; if (!done_seen) begin errors++; $display("FAIL rand_done got=0 exp=1"); end
  endtask

  initial begin
    s_RST_n = 0; sync_found = 0; in_strobe = 0; fft_ready = 0;
    @(posedge CLK); #1;
    test_reset();
    test_full_packet();
    test_fft_toggle();
    test_timeout();
    test_reset_mid();
    test_sync_ignore();
    test_sync_same_cycle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
